// File: rtl/pp_align_unit.sv
`default_nettype none
// ============================================================================
// Module   : pp_align_unit
// Brief    : Three-stage partial-product alignment for the FP MAC datapath.
//            Finds the block maximum exponent over non-zero lanes, right-shifts
//            each lane magnitude by its exponent distance and emits signed
//            two's-complement aligned values plus optional per-lane sticky.
// Revision : 1.0  initial release
// ============================================================================
module pp_align_unit #(
    parameter int N       = 4,
    parameter int EXP_W   = 5,
    parameter int MAN_W   = 4,
    parameter int ALIGN_W = 16,
    parameter int STICKY  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [N*EXP_W-1:0]   in_exp,
    input  logic [N-1:0]         in_sign,
    input  logic [N*MAN_W-1:0]   in_mag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [N*ALIGN_W-1:0] out_pp,
    output logic [EXP_W-1:0]     out_exp_max,
    output logic [N-1:0]         out_sticky
);

    // Aligned magnitude field width (output width minus the sign bit) and the
    // number of zero bits appended below the magnitude inside that field.
    localparam int FIELD_W = ALIGN_W - 1;
    localparam int PAD_W   = FIELD_W - MAN_W;

    // ------------------------------------------------------------------------
    // Pipeline state
    // ------------------------------------------------------------------------
    logic                   s1_valid_q,   s1_valid_d;
    logic [N-1:0]           s1_sign_q,    s1_sign_d;
    logic [N*MAN_W-1:0]     s1_mag_q,     s1_mag_d;
    logic [N*EXP_W-1:0]     s1_diff_q,    s1_diff_d;
    logic [EXP_W-1:0]       s1_exp_max_q, s1_exp_max_d;

    logic                   s2_valid_q,   s2_valid_d;
    logic [N-1:0]           s2_sign_q,    s2_sign_d;
    logic [N*FIELD_W-1:0]   s2_shf_q,     s2_shf_d;
    logic [N-1:0]           s2_sticky_q,  s2_sticky_d;
    logic [EXP_W-1:0]       s2_exp_max_q, s2_exp_max_d;

    logic                   out_valid_q,   out_valid_d;
    logic [N*ALIGN_W-1:0]   out_pp_q,      out_pp_d;
    logic [EXP_W-1:0]       out_exp_max_q, out_exp_max_d;
    logic [N-1:0]           out_sticky_q,  out_sticky_d;

    // ------------------------------------------------------------------------
    // Combinational datapath
    // ------------------------------------------------------------------------
    logic                   w_en;
    logic [EXP_W-1:0]       w_exp_max;
    logic [N*EXP_W-1:0]     w_diff;
    logic [N*FIELD_W-1:0]   w_shf;
    logic [N-1:0]           w_stk;
    logic [N*ALIGN_W-1:0]   w_pp;

    // The whole pipe moves together; it only freezes when a valid output is
    // being held back by the consumer.
    assign w_en     = !out_valid_q || out_ready;
    assign in_ready = w_en;

    // Block maximum exponent: zero-magnitude lanes do not participate, and an
    // all-zero beat falls out naturally as 0 because the search starts at 0.
    always_comb begin
        w_exp_max = '0;
        for (int i = 0; i < N; i++) begin
            if ((in_mag[i*MAN_W +: MAN_W] != '0) &&
                (in_exp[i*EXP_W +: EXP_W] > w_exp_max)) begin
                w_exp_max = in_exp[i*EXP_W +: EXP_W];
            end
        end
    end

    // Per-lane shift distance; zero lanes are forced to 0 so they never shift.
    always_comb begin
        w_diff = '0;
        for (int i = 0; i < N; i++) begin
            if (in_mag[i*MAN_W +: MAN_W] != '0) begin
                w_diff[i*EXP_W +: EXP_W] = w_exp_max - in_exp[i*EXP_W +: EXP_W];
            end
        end
    end

    // Stage 2 lanes: place magnitude at the top of the field, shift right by
    // the registered distance and optionally collect the bits that fall off.
    for (genvar gi = 0; gi < N; gi++) begin : g_lane
        logic [FIELD_W-1:0] w_field;
        logic [EXP_W-1:0]   w_lane_diff;
        logic               w_sat;

        assign w_lane_diff = s1_diff_q[gi*EXP_W +: EXP_W];
        assign w_field     = FIELD_W'(s1_mag_q[gi*MAN_W +: MAN_W]) << PAD_W;
        // A distance of a full field or more pushes every bit out.
        assign w_sat       = (32'(w_lane_diff) >= FIELD_W);
        assign w_shf[gi*FIELD_W +: FIELD_W] = w_sat ? '0 : (w_field >> w_lane_diff);

        if (STICKY != 0) begin : g_sticky
            logic [FIELD_W-1:0] w_lost_mask;
            // Mask of the low bits that the shift discards.
            assign w_lost_mask = w_sat ? '1 : ~({FIELD_W{1'b1}} << w_lane_diff);
            assign w_stk[gi]   = |(w_field & w_lost_mask);
        end else begin : g_no_sticky
            assign w_stk[gi] = 1'b0;
        end
    end

    // Stage 3 sign application: negating a zero magnitude wraps back to 0,
    // so a negative zero can never reach the adder tree.
    always_comb begin
        logic [ALIGN_W-1:0] v_ext;
        v_ext = '0;
        w_pp  = '0;
        for (int i = 0; i < N; i++) begin
            v_ext = {1'b0, s2_shf_q[i*FIELD_W +: FIELD_W]};
            w_pp[i*ALIGN_W +: ALIGN_W] = s2_sign_q[i] ? -v_ext : v_ext;
        end
    end

    // Next-state for every stage: hold everything while stalled, otherwise
    // advance one stage (bubbles included, nothing is collapsed).
    always_comb begin
        s1_valid_d    = s1_valid_q;
        s1_sign_d     = s1_sign_q;
        s1_mag_d      = s1_mag_q;
        s1_diff_d     = s1_diff_q;
        s1_exp_max_d  = s1_exp_max_q;
        s2_valid_d    = s2_valid_q;
        s2_sign_d     = s2_sign_q;
        s2_shf_d      = s2_shf_q;
        s2_sticky_d   = s2_sticky_q;
        s2_exp_max_d  = s2_exp_max_q;
        out_valid_d   = out_valid_q;
        out_pp_d      = out_pp_q;
        out_exp_max_d = out_exp_max_q;
        out_sticky_d  = out_sticky_q;
        if (w_en) begin
            s1_valid_d    = in_valid;
            s1_sign_d     = in_sign;
            s1_mag_d      = in_mag;
            s1_diff_d     = w_diff;
            s1_exp_max_d  = w_exp_max;

            s2_valid_d    = s1_valid_q;
            s2_sign_d     = s1_sign_q;
            s2_shf_d      = w_shf;
            s2_sticky_d   = w_stk;
            s2_exp_max_d  = s1_exp_max_q;

            out_valid_d   = s2_valid_q;
            out_pp_d      = w_pp;
            out_exp_max_d = s2_exp_max_q;
            out_sticky_d  = s2_sticky_q;
        end
    end

    // Pipeline registers; the asynchronous reset discards in-flight beats.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid_q    <= 1'b0;
            s1_sign_q     <= '0;
            s1_mag_q      <= '0;
            s1_diff_q     <= '0;
            s1_exp_max_q  <= '0;
            s2_valid_q    <= 1'b0;
            s2_sign_q     <= '0;
            s2_shf_q      <= '0;
            s2_sticky_q   <= '0;
            s2_exp_max_q  <= '0;
            out_valid_q   <= 1'b0;
            out_pp_q      <= '0;
            out_exp_max_q <= '0;
            out_sticky_q  <= '0;
        end else begin
            s1_valid_q    <= s1_valid_d;
            s1_sign_q     <= s1_sign_d;
            s1_mag_q      <= s1_mag_d;
            s1_diff_q     <= s1_diff_d;
            s1_exp_max_q  <= s1_exp_max_d;
            s2_valid_q    <= s2_valid_d;
            s2_sign_q     <= s2_sign_d;
            s2_shf_q      <= s2_shf_d;
            s2_sticky_q   <= s2_sticky_d;
            s2_exp_max_q  <= s2_exp_max_d;
            out_valid_q   <= out_valid_d;
            out_pp_q      <= out_pp_d;
            out_exp_max_q <= out_exp_max_d;
            out_sticky_q  <= out_sticky_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_pp      = out_pp_q;
    assign out_exp_max = out_exp_max_q;
    assign out_sticky  = out_sticky_q;

endmodule
`default_nettype wire

// File: tb/tb_pp_align_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_pp_align_unit
// Brief    : Self-checking bench for pp_align_unit (sticky and no-sticky builds)
//            with directed vectors, stall/reset scenarios and random streams
//            compared against an arithmetic reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_pp_align_unit;

    localparam int N       = 4;
    localparam int EXP_W   = 5;
    localparam int MAN_W   = 4;
    localparam int ALIGN_W = 16;
    localparam int FIELD_W = ALIGN_W - 1;

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic                 in_valid = 1'b0;
    logic                 out_ready = 1'b1;
    logic [N*EXP_W-1:0]   in_exp = '0;
    logic [N-1:0]         in_sign = '0;
    logic [N*MAN_W-1:0]   in_mag = '0;

    logic                 in_ready, out_valid;
    logic [N*ALIGN_W-1:0] out_pp;
    logic [EXP_W-1:0]     out_exp_max;
    logic [N-1:0]         out_sticky;

    logic                 in_ready_ns, out_valid_ns;
    logic [N*ALIGN_W-1:0] out_pp_ns;
    logic [EXP_W-1:0]     out_exp_max_ns;
    logic [N-1:0]         out_sticky_ns;

    pp_align_unit #(.N(N), .EXP_W(EXP_W), .MAN_W(MAN_W), .ALIGN_W(ALIGN_W), .STICKY(1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_exp(in_exp), .in_sign(in_sign), .in_mag(in_mag),
        .out_valid(out_valid), .out_ready(out_ready), .out_pp(out_pp),
        .out_exp_max(out_exp_max), .out_sticky(out_sticky)
    );

    pp_align_unit #(.N(N), .EXP_W(EXP_W), .MAN_W(MAN_W), .ALIGN_W(ALIGN_W), .STICKY(0)) dut_ns (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_ns),
        .in_exp(in_exp), .in_sign(in_sign), .in_mag(in_mag),
        .out_valid(out_valid_ns), .out_ready(out_ready), .out_pp(out_pp_ns),
        .out_exp_max(out_exp_max_ns), .out_sticky(out_sticky_ns)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N*ALIGN_W-1:0] pp;
        logic [EXP_W-1:0]     em;
        logic [N-1:0]         st;
    } beat_t;

    beat_t                exp_q[$];
    int                   n_checks = 0;
    int                   n_pass   = 0;
    bit                   acc_flag = 1'b0;
    bit                   stalled_prev = 1'b0;
    logic [N*ALIGN_W-1:0] prev_pp;
    logic [EXP_W-1:0]     prev_em;
    logic [N-1:0]         prev_st;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    endtask

    // Reference: value = mag * 2^PAD / 2^diff with integer division, sticky
    // is a non-zero remainder, negation is taken modulo 2^ALIGN_W.
    function automatic beat_t model(input logic [N*EXP_W-1:0] e,
                                    input logic [N-1:0]       s,
                                    input logic [N*MAN_W-1:0] m);
        beat_t  b;
        longint emax = 0;
        longint modv = longint'(1) << ALIGN_W;
        b.pp = '0;
        b.st = '0;
        for (int i = 0; i < N; i++) begin
            if (m[i*MAN_W +: MAN_W] != 0 && longint'(e[i*EXP_W +: EXP_W]) > emax)
                emax = longint'(e[i*EXP_W +: EXP_W]);
        end
        b.em = emax[EXP_W-1:0];
        for (int i = 0; i < N; i++) begin
            longint mi, f, d, q, r, v;
            mi = longint'(m[i*MAN_W +: MAN_W]);
            f  = mi * (longint'(1) << (FIELD_W - MAN_W));
            d  = (mi == 0) ? 0 : emax - longint'(e[i*EXP_W +: EXP_W]);
            q  = f / (longint'(1) << d);
            r  = f % (longint'(1) << d);
            v  = s[i] ? (modv - q) % modv : q;
            b.pp[i*ALIGN_W +: ALIGN_W] = v[ALIGN_W-1:0];
            b.st[i] = (r != 0);
        end
        return b;
    endfunction

    task automatic rand_beat();
        int base;
        base = $urandom_range(0, 27);
        for (int i = 0; i < N; i++) begin
            if ($urandom_range(0, 2) == 0)
                in_exp[i*EXP_W +: EXP_W] = EXP_W'($urandom_range(0, 31));
            else
                in_exp[i*EXP_W +: EXP_W] = EXP_W'(base + $urandom_range(0, 4));
            in_mag[i*MAN_W +: MAN_W] = ($urandom_range(0, 3) == 0) ? '0 : MAN_W'($urandom_range(1, 15));
            in_sign[i] = $urandom_range(0, 1) == 1;
        end
    endtask

    // Output monitor: accepted beats go into the scoreboard, delivered beats
    // are popped and compared, stalled outputs must not move.
    initial begin
        beat_t b;
        forever begin
            @(negedge clk);
            if (!rst) begin
                acc_flag     = 1'b0;
                stalled_prev = 1'b0;
            end else begin
                if (stalled_prev) begin
                    chk("hold_valid", out_valid, 1);
                    chk("hold_pp", out_pp, prev_pp);
                    chk("hold_exp_max", out_exp_max, prev_em);
                    chk("hold_sticky", out_sticky, prev_st);
                end
                if (out_valid && !out_ready) begin
                    chk("stall_in_ready", in_ready, 0);
                    chk("stall_in_ready_ns", in_ready_ns, 0);
                end
                if (out_valid && out_ready) begin
                    chk("beat_expected", exp_q.size() != 0, 1);
                    if (exp_q.size() != 0) begin
                        b = exp_q.pop_front();
                        chk("pp", out_pp, b.pp);
                        chk("exp_max", out_exp_max, b.em);
                        chk("sticky", out_sticky, b.st);
                        chk("ns_valid", out_valid_ns, 1);
                        chk("ns_pp", out_pp_ns, b.pp);
                        chk("ns_exp_max", out_exp_max_ns, b.em);
                        chk("ns_sticky", out_sticky_ns, 0);
                    end
                end
                acc_flag = in_valid && in_ready;
                if (acc_flag) exp_q.push_back(model(in_exp, in_sign, in_mag));
                stalled_prev = out_valid && !out_ready;
                prev_pp = out_pp;
                prev_em = out_exp_max;
                prev_st = out_sticky;
            end
        end
    end

    task automatic send_one(input logic [N*EXP_W-1:0] e, input logic [N-1:0] s,
                            input logic [N*MAN_W-1:0] m);
        int c = 0;
        in_exp = e; in_sign = s; in_mag = m; in_valid = 1'b1;
        do begin
            @(posedge clk); #1; c++;
        end while (!acc_flag && c < 20);
        chk("send_accept", acc_flag, 1);
        in_valid = 1'b0;
    endtask

    // Single beat into an empty pipe: check the 3-edge latency and the
    // hand-computed results on both builds.
    task automatic send_expect(input string tag,
                               input logic [N*EXP_W-1:0] e, input logic [N-1:0] s,
                               input logic [N*MAN_W-1:0] m,
                               input logic [N*ALIGN_W-1:0] pp, input logic [EXP_W-1:0] em,
                               input logic [N-1:0] st);
        int k = 0;
        out_ready = 1'b1;
        send_one(e, s, m);
        while (!out_valid && k < 6) begin
            @(posedge clk); #1; k++;
        end
        chk({tag, "_latency"}, k, 2);
        chk({tag, "_pp"}, out_pp, pp);
        chk({tag, "_exp_max"}, out_exp_max, em);
        chk({tag, "_sticky"}, out_sticky, st);
        chk({tag, "_ns_pp"}, out_pp_ns, pp);
        chk({tag, "_ns_sticky"}, out_sticky_ns, 0);
        @(posedge clk); #1;
    endtask

    task automatic run_stream(input int nbeats, input bit rnd);
        int sent = 0;
        int c = 0;
        bit have = 1'b0;
        while (sent < nbeats && c < 3000) begin
            if (have && acc_flag) begin sent++; have = 1'b0; end
            if (!have && sent < nbeats && (!rnd || $urandom_range(0, 3) != 0)) begin
                rand_beat();
                have = 1'b1;
            end
            in_valid  = have;
            out_ready = rnd ? ($urandom_range(0, 3) != 0) : !(c >= 4 && c <= 7);
            @(posedge clk); #1; c++;
        end
        in_valid = 1'b0;
        chk("stream_sent", sent, nbeats);
    endtask

    task automatic drain();
        int c = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while (exp_q.size() != 0 && c < 50) begin
            @(posedge clk); #1; c++;
        end
        chk("drain_empty", exp_q.size(), 0);
        repeat (4) begin @(posedge clk); #1; end
    endtask

    initial begin
        // Reset state
        @(posedge clk); #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_pp", out_pp, 0);
        chk("rst_exp_max", out_exp_max, 0);
        chk("rst_sticky", out_sticky, 0);
        chk("rst_in_ready", in_ready, 1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        // Directed vectors (lane 0 in the low bits)
        send_expect("mixed", {5'd7, 5'd12, 5'd12, 5'd10}, 4'b0010, {4'hC, 4'h1, 4'h8, 4'hF},
                    64'h0300_0800_C000_1E00, 5'd12, 4'b0000);
        send_expect("far14", {5'd25, 5'd25, 5'd14, 5'd0}, 4'b0000, {4'h0, 4'h0, 4'h1, 4'hF},
                    64'h0000_0000_0800_0001, 5'd14, 4'b0001);
        send_expect("far20", {5'd25, 5'd25, 5'd20, 5'd0}, 4'b0000, {4'h0, 4'h0, 4'h1, 4'hF},
                    64'h0000_0000_0800_0000, 5'd20, 4'b0001);
        send_expect("negzero", {5'd3, 5'd3, 5'd3, 5'd31}, 4'b0001, {4'h2, 4'h2, 4'h2, 4'h0},
                    64'h1000_1000_1000_0000, 5'd3, 4'b0000);
        send_expect("allzero", {5'd9, 5'd30, 5'd4, 5'd17}, 4'b1111, 16'h0000,
                    64'h0000_0000_0000_0000, 5'd0, 4'b0000);
        send_expect("negsticky", {5'd0, 5'd0, 5'd13, 5'd0}, 4'b0001, {4'h0, 4'h0, 4'h1, 4'h3},
                    64'h0000_0000_0800_0000, 5'd13, 4'b0001);
        drain();

        // Six back-to-back beats with the consumer stalled for four cycles
        run_stream(6, 1'b0);
        drain();

        // Asynchronous reset with two beats in flight and the output stalled
        out_ready = 1'b0;
        rand_beat(); in_valid = 1'b1;
        @(posedge clk); #1;
        rand_beat();
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("rst_pre_valid", out_valid, 1);
        #1;
        rst = 1'b0;
        exp_q.delete();
        #1;
        chk("arst_out_valid", out_valid, 0);
        chk("arst_out_pp", out_pp, 0);
        chk("arst_exp_max", out_exp_max, 0);
        chk("arst_sticky", out_sticky, 0);
        chk("arst_ns_valid", out_valid_ns, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        out_ready = 1'b1;
        chk("arst_in_ready", in_ready, 1);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            chk("no_stale_beat", out_valid, 0);
        end

        // Randomized streams with random valid and ready
        run_stream(80, 1'b1);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
